// File: rtl/pixel_pkg.sv
// rtl/pixel_pkg.sv - shared constants and types for the double-banked pixel buffer
package pixel_pkg;
   localparam int PIXELS = 64;
   localparam int ADDR_W = 6;
   localparam int DATA_W = 24;

   typedef logic [DATA_W-1:0] pixel_t;

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      SWAP_WAIT = 2'd1,
      COPY_RD   = 2'd2,
      COPY_WR   = 2'd3
   } arb_state_t;
endpackage

// File: rtl/pixel_buf_arbiter_if.sv
// rtl/pixel_buf_arbiter_if.sv - single-port pixel RAM bus between arbiter (master) and RAM macro (slave)
interface pixel_buf_arbiter_if;
   import pixel_pkg::*;

   logic            mem_en;
   logic            mem_we;
   logic [ADDR_W:0] mem_addr;
   pixel_t          mem_wdata;
   pixel_t          mem_rdata;

   modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
   modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata, output mem_rdata);
endinterface

// File: rtl/pixel_buf_arbiter.sv
// rtl/pixel_buf_arbiter.sv - arbitrates the banked pixel RAM between display reads, bank copy and writer
// All state updates on the falling clock edge to line up with the frame sequencer.
module pixel_buf_arbiter
   import pixel_pkg::*;
#(
   parameter bit COPY_EN = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic              rd_valid,
   output pixel_t            rd_data,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  pixel_t            wr_data,
   output logic              wr_grant,
   input  logic              frame_done,
   input  logic              wr_frame_done,
   pixel_buf_arbiter_if.master mem,
   output logic              front_buf,
   output logic              swap,
   output logic              busy,
   output logic              overrun
);

   arb_state_t        state_q, state_d;
   logic              front_q, front_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   pixel_t            hold_q, hold_d;
   pixel_t            rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic              swap_q, swap_d;
   logic              overrun_q, overrun_d;
   logic              pend_q, pend_d;
   logic              tag_q, tag_d;

   logic              en, we, grant, do_swap;
   logic [ADDR_W:0]   addr;
   pixel_t            wdata, copy_data;

   always_comb begin
      state_d    = state_q;
      front_d    = front_q;
      idx_d      = idx_q;
      hold_d     = hold_q;
      swap_d     = 1'b0;
      pend_d     = 1'b0;
      tag_d      = 1'b0;
      overrun_d  = overrun_q | (wr_frame_done & (state_q != RUN));
      en         = 1'b0;
      we         = 1'b0;
      grant      = 1'b0;
      do_swap    = 1'b0;
      addr       = '0;
      wdata      = '0;

      // tag_q says whether last cycle's read belongs to the display (0) or the copy (1)
      rd_valid_d = pend_q & ~tag_q;
      rd_data_d  = (pend_q & ~tag_q) ? mem.mem_rdata : rd_data_q;
      if (pend_q & tag_q)
         hold_d = mem.mem_rdata;
      copy_data  = (pend_q & tag_q) ? mem.mem_rdata : hold_q;

      if (rd_req) begin
         en     = 1'b1;
         addr   = {front_q, rd_addr};
         pend_d = 1'b1;
      end

      case (state_q)
         RUN: begin
            if (wr_req && !rd_req) begin
               grant = 1'b1;
               en    = 1'b1;
               we    = 1'b1;
               addr  = {~front_q, wr_addr};
               wdata = wr_data;
            end
            if (wr_frame_done && frame_done)
               do_swap = 1'b1;
            else if (wr_frame_done)
               state_d = SWAP_WAIT;
         end
         SWAP_WAIT: begin
            if (frame_done)
               do_swap = 1'b1;
         end
         COPY_RD: begin
            if (!rd_req) begin
               en      = 1'b1;
               addr    = {front_q, idx_q};
               pend_d  = 1'b1;
               tag_d   = 1'b1;
               state_d = COPY_WR;
            end
         end
         COPY_WR: begin
            if (!rd_req) begin
               en    = 1'b1;
               we    = 1'b1;
               addr  = {~front_q, idx_q};
               wdata = copy_data;
               if (idx_q == ADDR_W'(PIXELS - 1)) begin
                  state_d = RUN;
               end else begin
                  idx_d   = idx_q + 1'b1;
                  state_d = COPY_RD;
               end
            end
         end
         default: state_d = RUN;
      endcase

      if (do_swap) begin
         front_d = ~front_q;
         swap_d  = 1'b1;
         idx_d   = '0;
         state_d = COPY_EN ? COPY_RD : RUN;
      end

      if (rst) begin
         en    = 1'b0;
         we    = 1'b0;
         grant = 1'b0;
      end
   end

   always_ff @(negedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         front_q    <= 1'b0;
         idx_q      <= '0;
         hold_q     <= '0;
         rd_data_q  <= '0;
         rd_valid_q <= 1'b0;
         swap_q     <= 1'b0;
         overrun_q  <= 1'b0;
         pend_q     <= 1'b0;
         tag_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         front_q    <= front_d;
         idx_q      <= idx_d;
         hold_q     <= hold_d;
         rd_data_q  <= rd_data_d;
         rd_valid_q <= rd_valid_d;
         swap_q     <= swap_d;
         overrun_q  <= overrun_d;
         pend_q     <= pend_d;
         tag_q      <= tag_d;
      end
   end

   assign mem.mem_en    = en;
   assign mem.mem_we    = we;
   assign mem.mem_addr  = addr;
   assign mem.mem_wdata = wdata;
   assign wr_grant      = grant;
   assign rd_valid      = rd_valid_q;
   assign rd_data       = rd_data_q;
   assign front_buf     = front_q;
   assign swap          = swap_q;
   assign busy          = (state_q != RUN);
   assign overrun       = overrun_q;

endmodule

// File: tb/tb_pixel_buf_arbiter.sv
// tb/tb_pixel_buf_arbiter.sv - directed self-checking bench for pixel_buf_arbiter
module tb_pixel_buf_arbiter;
   import pixel_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, rd_req, wr_req, frame_done, wr_frame_done;
   logic [5:0]  rd_addr, wr_addr;
   pixel_t      wr_data, rd_data;
   logic        rd_valid, wr_grant, front_buf, swap, busy, overrun;

   pixel_buf_arbiter_if mem_bus ();

   pixel_buf_arbiter #(.COPY_EN(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .rd_req       (rd_req),
      .rd_addr      (rd_addr),
      .rd_valid     (rd_valid),
      .rd_data      (rd_data),
      .wr_req       (wr_req),
      .wr_addr      (wr_addr),
      .wr_data      (wr_data),
      .wr_grant     (wr_grant),
      .frame_done   (frame_done),
      .wr_frame_done(wr_frame_done),
      .mem          (mem_bus),
      .front_buf    (front_buf),
      .swap         (swap),
      .busy         (busy),
      .overrun      (overrun)
   );

   // RAM macro model: preloaded while rst is high, one-cycle read latency
   pixel_t ram [0:127];
   pixel_t ram_rdata = '0;
   assign mem_bus.mem_rdata = ram_rdata;

   always @(negedge clk) begin
      if (rst) begin
         for (int i = 0; i < 64; i++) begin
            ram[i]      <= 24'hA00000 | 24'(i);
            ram[64 + i] <= 24'hB00000 | 24'(i);
         end
         ram[5] <= 24'h00FF00;
      end else if (mem_bus.mem_en) begin
         if (mem_bus.mem_we)
            ram[mem_bus.mem_addr] <= mem_bus.mem_wdata;
         else
            ram_rdata <= ram[mem_bus.mem_addr];
      end
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic cyc;
      @(negedge clk);
      #1;
   endtask

   task automatic smp;
      @(posedge clk);
   endtask

   function automatic pixel_t bank1_after_wr(int i);
      return (i == 3) ? 24'h123456 : (24'hB00000 | 24'(i));
   endfunction

   function automatic pixel_t bank0_after_wr(int i);
      if (i == 0)  return 24'hAAAAAA;
      if (i == 63) return 24'hBBBBBB;
      return bank1_after_wr(i);
   endfunction

   int     busy_bad, nbusy, nswap, errs, done;
   logic   p1v, p2v;
   pixel_t p1d, p2d;

   initial begin
      rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0;
      wr_data = '0; frame_done = 1'b0; wr_frame_done = 1'b0;
      cyc; cyc;

      wr_req = 1'b1; rd_req = 1'b1;
      smp;
      chk("rst_grant", 32'(wr_grant), 0);
      chk("rst_mem_en", 32'(mem_bus.mem_en), 0);
      chk("rst_front", 32'(front_buf), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_flags", 32'({rd_valid, swap, overrun}), 0);
      chk("rst_rd_data", 32'(rd_data), 0);

      cyc;
      rst = 1'b0; wr_req = 1'b0; rd_req = 1'b1; rd_addr = 6'd5;
      smp;
      chk("rd_issue_addr", 32'(mem_bus.mem_addr), 'h05);
      chk("rd_issue_en", 32'({mem_bus.mem_en, mem_bus.mem_we}), 'b10);
      cyc;
      rd_req = 1'b0;
      smp;
      chk("rd_n1_valid", 32'(rd_valid), 0);
      cyc;
      smp;
      chk("rd_n2_valid", 32'(rd_valid), 1);
      chk("rd_n2_data", 32'(rd_data), 'h00FF00);
      cyc;
      smp;
      chk("rd_n3_valid", 32'(rd_valid), 0);

      cyc;
      wr_req = 1'b1; wr_addr = 6'd3; wr_data = 24'h123456; rd_req = 1'b1; rd_addr = 6'd0;
      for (int k = 0; k < 4; k++) begin
         smp;
         chk("wr_blocked", 32'(wr_grant), 0);
         cyc;
      end
      rd_req = 1'b0;
      smp;
      chk("wr_grant", 32'(wr_grant), 1);
      chk("wr_addr", 32'(mem_bus.mem_addr), 'h43);
      chk("wr_we", 32'(mem_bus.mem_we), 1);
      chk("wr_wdata", 32'(mem_bus.mem_wdata), 'h123456);
      cyc;
      wr_req = 1'b0;
      smp;
      chk("wr_ram", 32'(ram[67]), 'h123456);

      cyc;
      frame_done = 1'b1;
      smp;
      cyc;
      frame_done = 1'b0;
      smp;
      chk("fd_alone_swap", 32'({swap, front_buf, busy}), 0);

      cyc;
      wr_frame_done = 1'b1;
      smp;
      cyc;
      wr_frame_done = 1'b0;
      busy_bad = 0;
      for (int k = 1; k < 10; k++) begin
         smp;
         if (!busy || front_buf) busy_bad++;
         cyc;
      end
      chk("swait_busy", 32'(busy_bad), 0);
      frame_done = 1'b1;
      smp;
      chk("swait_last_busy", 32'(busy), 1);
      cyc;
      frame_done = 1'b0;
      nbusy = 0; nswap = 0;
      for (int k = 0; k < 1000; k++) begin
         smp;
         if (k == 0) chk("swap_front", 32'(front_buf), 1);
         if (swap) nswap++;
         if (!busy) break;
         nbusy++;
         cyc;
      end
      chk("copy_cycles", 32'(nbusy), 128);
      chk("swap_pulses", 32'(nswap), 1);
      cyc;
      errs = 0;
      for (int i = 0; i < 64; i++)
         if (ram[i] !== bank1_after_wr(i)) errs++;
      chk("copy1_words", 32'(errs), 0);

      wr_req = 1'b1; wr_addr = 6'd0; wr_data = 24'hAAAAAA;
      smp;
      chk("wr_back0_grant", 32'(wr_grant), 1);
      chk("wr_back0_addr", 32'(mem_bus.mem_addr), 'h00);
      cyc;
      wr_addr = 6'd63; wr_data = 24'hBBBBBB;
      smp;
      chk("wr_back63_addr", 32'(mem_bus.mem_addr), 'h3F);
      cyc;
      wr_req = 1'b0;

      wr_frame_done = 1'b1; frame_done = 1'b1;
      smp;
      cyc;
      frame_done = 1'b0;
      p1v = 1'b0; p2v = 1'b0; p1d = '0; p2d = '0; done = 0;
      for (int c = 0; c < 1000; c++) begin
         rd_req = (c % 3 == 0);
         rd_addr = 6'(c * 5);
         wr_frame_done = (c == 7);
         smp;
         if (c == 0) begin
            chk("both_swap", 32'(swap), 1);
            chk("both_front", 32'(front_buf), 0);
            chk("both_busy", 32'(busy), 1);
         end
         chk("dly_valid", 32'(rd_valid), 32'(p2v));
         if (p2v) chk("dly_data", 32'(rd_data), 32'(p2d));
         p2v = p1v; p2d = p1d;
         p1v = rd_req; p1d = bank0_after_wr(int'(rd_addr));
         if (!busy) begin
            done = 1;
            break;
         end
         cyc;
      end
      chk("copy2_done", 32'(done), 1);
      wr_frame_done = 1'b0;
      for (int d = 0; d < 2; d++) begin
         cyc;
         rd_req = 1'b0;
         smp;
         chk("drain_valid", 32'(rd_valid), 32'(p2v));
         if (p2v) chk("drain_data", 32'(rd_data), 32'(p2d));
         p2v = p1v; p2d = p1d; p1v = 1'b0;
      end
      errs = 0;
      for (int i = 0; i < 64; i++)
         if (ram[64 + i] !== bank0_after_wr(i)) errs++;
      chk("copy2_words", 32'(errs), 0);
      chk("copy2_last", 32'(ram[127]), 'hBBBBBB);
      cyc;
      smp;
      chk("overrun_sticky", 32'(overrun), 1);

      cyc;
      wr_frame_done = 1'b1; frame_done = 1'b1;
      smp;
      cyc;
      wr_frame_done = 1'b0; frame_done = 1'b0;
      for (int k = 0; k < 41; k++) begin
         smp;
         if (k == 0)  chk("swap3_front", 32'(front_buf), 1);
         if (k == 40) chk("ovr_before_rst", 32'(overrun), 1);
         cyc;
      end
      rst = 1'b1; wr_req = 1'b1; wr_addr = 6'd9; rd_req = 1'b1;
      smp;
      chk("mid_rst_grant", 32'(wr_grant), 0);
      chk("mid_rst_en", 32'({mem_bus.mem_en, mem_bus.mem_we}), 0);
      cyc;
      rst = 1'b0; rd_req = 1'b0;
      smp;
      chk("post_rst_front", 32'(front_buf), 0);
      chk("post_rst_busy", 32'(busy), 0);
      chk("post_rst_overrun", 32'(overrun), 0);
      chk("post_rst_pulses", 32'({swap, rd_valid}), 0);
      chk("post_rst_grant", 32'(wr_grant), 1);
      chk("post_rst_addr", 32'(mem_bus.mem_addr), 'h49);
      cyc;
      wr_req = 1'b0;
      cyc;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
